// File: rtl/led_sequencer.sv
// led_sequencer: multi-channel status LED controller driven by one shared
// timebase tick. Each channel runs OFF / ON / BLINK / PULSE, configured
// through a single command port.
//
// Command handshake: a command transfers on a rising clk edge where
// cmd_valid && cmd_ready are both high. cmd_ready is combinational. It drops
// only when the addressed channel is running a PULSE and the new command is
// not OFF, so OFF is the only way to abort a pulse train. While cmd_ready is
// low the sender holds cmd_* stable. A command addressed past the last
// channel is accepted and has no effect.
module led_sequencer #(
    parameter int NUM_LEDS = 4,
    parameter int TICK_DIV = 50000,
    parameter int PERIOD_W = 16,
    localparam int SEL_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [SEL_W-1:0]    cmd_sel,
    input  logic [1:0]          cmd_mode,
    input  logic [PERIOD_W-1:0] cmd_half,
    input  logic [7:0]          cmd_count,
    output logic [NUM_LEDS-1:0] led,
    output logic [NUM_LEDS-1:0] busy,
    output logic [NUM_LEDS-1:0] done
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PULSE = 2'd3
    } mode_e;

    // Shared prescaler
    logic [CNT_W-1:0] presc_q;
    logic             tick;

    // Per-channel state. mode_q is the per-channel FSM state and can be
    // probed hierarchically alongside the outputs.
    mode_e               mode_q  [NUM_LEDS];
    mode_e               mode_d  [NUM_LEDS];
    logic [PERIOD_W-1:0] half_q  [NUM_LEDS];
    logic [PERIOD_W-1:0] half_d  [NUM_LEDS];
    logic [PERIOD_W-1:0] timer_q [NUM_LEDS];
    logic [PERIOD_W-1:0] timer_d [NUM_LEDS];
    logic [7:0]          rem_q   [NUM_LEDS];
    logic [7:0]          rem_d   [NUM_LEDS];
    logic [NUM_LEDS-1:0] led_q;
    logic [NUM_LEDS-1:0] led_d;
    logic [NUM_LEDS-1:0] busy_q;
    logic [NUM_LEDS-1:0] busy_d;
    logic [NUM_LEDS-1:0] done_q;
    logic [NUM_LEDS-1:0] done_d;

    logic                busy_sel;
    logic [NUM_LEDS-1:0] accept;
    logic [PERIOD_W-1:0] cmd_half_eff;

    // Free-running timebase; commands never restart it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + CNT_W'(1);
        end
    end

    assign tick = (presc_q == CNT_W'(TICK_DIV - 1));

    // Busy flag of the addressed channel; out-of-range selects read as idle.
    always_comb begin
        busy_sel = 1'b0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (cmd_sel == SEL_W'(i)) begin
                busy_sel = busy_q[i];
            end
        end
    end

    assign cmd_ready    = !(busy_sel && (cmd_mode != MODE_OFF));
    assign cmd_half_eff = (cmd_half == '0) ? PERIOD_W'(1) : cmd_half;

    // Per-channel accept decode.
    always_comb begin
        accept = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            accept[i] = cmd_valid && cmd_ready && (cmd_sel == SEL_W'(i));
        end
    end

    // Per-channel next state: an accepted command takes priority over the
    // tick in the same cycle; ON and OFF never look at the tick.
    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            mode_d[i]  = mode_q[i];
            half_d[i]  = half_q[i];
            timer_d[i] = timer_q[i];
            rem_d[i]   = rem_q[i];
            led_d[i]   = led_q[i];
            busy_d[i]  = busy_q[i];
            done_d[i]  = 1'b0;

            if (accept[i]) begin
                case (mode_e'(cmd_mode))
                    MODE_OFF: begin
                        mode_d[i] = MODE_OFF;
                        led_d[i]  = 1'b0;
                        busy_d[i] = 1'b0;
                    end
                    MODE_ON: begin
                        mode_d[i] = MODE_ON;
                        led_d[i]  = 1'b1;
                        busy_d[i] = 1'b0;
                    end
                    MODE_BLINK: begin
                        mode_d[i]  = MODE_BLINK;
                        half_d[i]  = cmd_half_eff;
                        timer_d[i] = '0;
                        led_d[i]   = 1'b1;
                        busy_d[i]  = 1'b0;
                    end
                    default: begin
                        if (cmd_count != 8'd0) begin
                            mode_d[i]  = MODE_PULSE;
                            half_d[i]  = cmd_half_eff;
                            timer_d[i] = '0;
                            rem_d[i]   = cmd_count;
                            led_d[i]   = 1'b1;
                            busy_d[i]  = 1'b1;
                        end else begin
                            // Empty pulse train: complete immediately.
                            mode_d[i] = MODE_OFF;
                            led_d[i]  = 1'b0;
                            busy_d[i] = 1'b0;
                            done_d[i] = 1'b1;
                        end
                    end
                endcase
            end else if (tick && ((mode_q[i] == MODE_BLINK) ||
                                  (mode_q[i] == MODE_PULSE))) begin
                if (timer_q[i] == (half_q[i] - PERIOD_W'(1))) begin
                    timer_d[i] = '0;
                    led_d[i]   = ~led_q[i];
                    // A falling edge closes one pulse; the last one ends
                    // the train with no trailing off-phase.
                    if ((mode_q[i] == MODE_PULSE) && led_q[i]) begin
                        if (rem_q[i] == 8'd1) begin
                            mode_d[i] = MODE_OFF;
                            busy_d[i] = 1'b0;
                            done_d[i] = 1'b1;
                        end else begin
                            rem_d[i] = rem_q[i] - 8'd1;
                        end
                    end
                end else begin
                    timer_d[i] = timer_q[i] + PERIOD_W'(1);
                end
            end
        end
    end

    // Per-channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                mode_q[i]  <= MODE_OFF;
                half_q[i]  <= PERIOD_W'(1);
                timer_q[i] <= '0;
                rem_q[i]   <= '0;
            end
            led_q  <= '0;
            busy_q <= '0;
            done_q <= '0;
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                mode_q[i]  <= mode_d[i];
                half_q[i]  <= half_d[i];
                timer_q[i] <= timer_d[i];
                rem_q[i]   <= rem_d[i];
            end
            led_q  <= led_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign led  = led_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with TICK_DIV=4.
module tb_led_sequencer;

    localparam int NUM_LEDS = 4;
    localparam int TICK_DIV = 4;
    localparam int PERIOD_W = 16;

    logic                clk;
    logic                rst_n;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_sel;
    logic [1:0]          cmd_mode;
    logic [PERIOD_W-1:0] cmd_half;
    logic [7:0]          cmd_count;
    logic [NUM_LEDS-1:0] led;
    logic [NUM_LEDS-1:0] busy;
    logic [NUM_LEDS-1:0] done;

    int checks;
    int failures;
    int pc;

    led_sequencer #(
        .NUM_LEDS(NUM_LEDS),
        .TICK_DIV(TICK_DIV),
        .PERIOD_W(PERIOD_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_sel  (cmd_sel),
        .cmd_mode (cmd_mode),
        .cmd_half (cmd_half),
        .cmd_count(cmd_count),
        .led      (led),
        .busy     (busy),
        .done     (done)
    );

    // Clock and reference timebase phase
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= 0;
        else        pc <= (pc == TICK_DIV - 1) ? 0 : pc + 1;
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance until the cycle in which the timebase counter equals p.
    task automatic wait_phase(input int p);
        for (int n = 0; n < 2 * TICK_DIV && pc != p; n++) step();
    endtask

    // Present one command, confirm it is ready, and let it be accepted.
    task automatic send(input logic [1:0] sel, input logic [1:0] mode,
                        input logic [15:0] half, input logic [7:0] count);
        cmd_valid = 1'b1;
        cmd_sel   = sel;
        cmd_mode  = mode;
        cmd_half  = half;
        cmd_count = count;
        #1;
        check("send_ready", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_sel   = '0;
        cmd_mode  = '0;
        cmd_half  = '0;
        cmd_count = '0;

        // Reset and idle
        #3;
        check("rst_outputs", 32'({led, busy, done}), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 100; k++) begin
            step();
            check("idle", 32'({led, busy, done, cmd_ready}), 32'd1);
        end

        // BLINK ch1, half=2, accepted from a phase-0 cycle: first tick
        // three edges later, so the first high phase is 7 cycles, then 8.
        wait_phase(0);
        send(2'd1, 2'd2, 16'd2, 8'd0);
        for (int k = 0; k < 24; k++) begin
            check("blink_led1", 32'(led[1]),
                  32'((k < 7) ? 1'b1 : ((((k - 7) / 8) % 2) == 1)));
            check("blink_others", 32'({led[3:2], led[0]}), 32'd0);
            check("blink_busy", 32'(busy), 32'd0);
            step();
        end
        send(2'd1, 2'd0, 16'd0, 8'd0);
        check("blink_off", 32'(led), 32'd0);

        // PULSE ch0, count=3, half=1, with a held BLINK while busy
        wait_phase(0);
        send(2'd0, 2'd3, 16'd1, 8'd3);
        for (int k = 0; k < 23; k++) begin
            check("pulse_led0", 32'(led[0]),
                  32'((k < 3) || (k >= 7 && k < 11) || (k >= 15 && k < 19)));
            check("pulse_busy0", 32'(busy[0]), 32'(k < 19));
            check("pulse_done0", 32'(done[0]), 32'(k == 19));
            if (k >= 1 && k <= 3) begin
                cmd_valid = 1'b1;
                cmd_sel   = 2'd0;
                cmd_mode  = 2'd2;
                cmd_half  = 16'd5;
                #1;
                check("override_ready", 32'(cmd_ready), 32'd0);
            end
            if (k == 4) cmd_valid = 1'b0;
            step();
        end

        // Abort a running PULSE with OFF
        wait_phase(0);
        send(2'd0, 2'd3, 16'd1, 8'd3);
        for (int k = 0; k < 9; k++) begin
            check("abort_pre_led0", 32'(led[0]),
                  32'((k < 3) || (k >= 7 && k < 11)));
            if (k < 8) step();
        end
        cmd_valid = 1'b1;
        cmd_sel   = 2'd0;
        cmd_mode  = 2'd0;
        #1;
        check("abort_ready", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        check("abort_led_busy", 32'({led[0], busy[0]}), 32'd0);
        for (int k = 0; k < 24; k++) begin
            check("abort_quiet", 32'({led[0], busy[0], done[0]}), 32'd0);
            step();
        end

        // PULSE with count=0 on ch2
        send(2'd2, 2'd3, 16'd1, 8'd0);
        check("cnt0_done", 32'(done), 32'b0100);
        check("cnt0_led_busy", 32'({led, busy}), 32'd0);
        step();
        check("cnt0_done_clear", 32'(done), 32'd0);
        for (int k = 0; k < 8; k++) begin
            step();
            check("cnt0_quiet", 32'({led, busy, done}), 32'd0);
        end

        // BLINK ch3, half=1, accepted in a tick cycle: full first phase
        wait_phase(TICK_DIV - 1);
        send(2'd3, 2'd2, 16'd1, 8'd0);
        for (int k = 0; k < 10; k++) begin
            check("coll_led3", 32'(led[3]), 32'((k < 4) || (k >= 8)));
            if (k < 9) step();
        end

        // Asynchronous reset mid-blink
        rst_n = 1'b0;
        #1;
        check("async_rst_out", 32'({led, busy, done}), 32'd0);
        check("async_rst_ready", 32'(cmd_ready), 32'd1);
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            check("post_rst", 32'({led, busy, done}), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Multi-channel LED controller that sequences a bank of status LEDs from a single shared timebase. Each channel is configured through a valid/ready command port to be off, on, blinking continuously, or emitting a fixed number of pulses. One free-running prescaler replaces a per-LED divider. The block sits between the frame-buffer control logic and the board LED pins.

## Interface
- NUM_LEDS, 4, number of LED channels (1–16)
- TICK_DIV, 50000, clk cycles per timebase tick (≥2)
- PERIOD_W, 16, width of half-period field, in ticks
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command can be accepted this cycle
- cmd_sel  in  max(1,$clog2(NUM_LEDS))  target channel
- cmd_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=PULSE
- cmd_half  in  PERIOD_W  half-period in ticks; 0 is treated as 1
- cmd_count  in  8  pulse count for PULSE mode
- led  out  NUM_LEDS  LED drive, registered
- busy  out  NUM_LEDS  channel is executing a PULSE command
- done  out  NUM_LEDS  one-cycle strobe when a PULSE command completes

## Operation
- Prescaler: counter 0..TICK_DIV-1, free-running and never restarted by commands. `tick` is high for one cycle when the counter equals TICK_DIV-1.
- Per-channel state: mode, half, phase timer (PERIOD_W bits), remaining count (8 bits), led register.
- A command is accepted when cmd_valid && cmd_ready.
- cmd_ready is combinational: low only when busy[cmd_sel] is set and cmd_mode != OFF. A running PULSE can be aborted only by OFF.
- cmd_sel ≥ NUM_LEDS: the command is accepted and ignored.
- Effect of an accepted command on the next cycle:
  - OFF: led=0, busy=0, no done.
  - ON: led=1.
  - BLINK: led=1, timer=0.
  - PULSE with count>0: led=1, timer=0, remaining=count, busy=1.
  - PULSE with count=0: led stays 0, busy stays 0, done strobes once.
- BLINK/PULSE stepping, on each tick:
  - If timer == half-1: timer=0 and led toggles.
  - Otherwise timer increments.
- PULSE completion:
  - On a 1→0 toggle with remaining==1: led=0, mode=OFF, busy=0, done=1 for that one cycle.
  - On any other 1→0 toggle, remaining decrements.
  - No trailing off-phase follows the last pulse.
- A channel's accepted command and its tick in the same cycle: the command wins and the tick is ignored for that channel.
- ON and OFF ignore ticks.
- A new non-OFF command to a non-busy channel restarts it from its first high phase.

## Timing
- Reset values: led=0, busy=0, done=0, all modes OFF, prescaler=0. cmd_ready=1 during and after reset.
- Latency: led, busy and done change the cycle after the accept or tick that causes them.
- Phase length:
  - All phases except the first last exactly half×TICK_DIV cycles.
  - The first high phase lasts between (half-1)×TICK_DIV+1 and half×TICK_DIV cycles, depending on prescaler alignment.
- done is coincident with the final led 1→0 edge, lasts exactly one cycle, and is not asserted on abort.
- Reset asserted mid-operation: all outputs go to reset values asynchronously. Nothing resumes after release.
- Channels are independent. Simultaneous ticks on all channels are handled in the same cycle.

## Test plan
All scenarios use TICK_DIV=4.
- Reset and idle: assert rst_n low, then release → led=0, busy=0, done=0, cmd_ready=1; no activity for 100 cycles.
- BLINK on channel 1, half=2:
  - led[1] rises the cycle after accept.
  - After the first phase, it toggles every 8 cycles.
  - Other LEDs stay 0.
- PULSE on channel 0, count=3, half=1:
  - Three high pulses of 4 cycles each, the first pulse 1–4 cycles.
  - busy[0]=1 from the cycle after accept until the final fall.
  - done[0]=1 for one cycle, coincident with the third fall.
  - led[0]=0 afterwards.
- Busy override:
  - During the scenario-3 PULSE, drive a BLINK command to channel 0 → cmd_ready=0 and the command is held.
  - Drive OFF instead → accepted immediately; next cycle led[0]=0, busy[0]=0, done[0] never asserts.
- PULSE with count=0 on channel 2 → done[2] strobes for one cycle the cycle after accept; led[2] and busy[2] stay 0.
- Collision and reset:
  - Accept BLINK on channel 3 in a tick cycle → timer=0, with no toggle that cycle.
  - Then assert rst_n mid-blink → led[3]=0 immediately; after release it stays 0.
